// File: rtl/ps2_receiver_pkg.sv
// Shared PS/2 definitions: frame states, frame length and default timing.
// Also intended for reuse by the future PS/2 transmitter.
package ps2_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int FRAME_BITS        = 11;
    localparam int FILTER_LEN_DEF    = 16;
    localparam int TIMEOUT_TICKS_DEF = 340;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// Received-byte bundle from the PS/2 receiver to its consumer.
interface ps2_rx_if;

    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;
    logic       busy;

    modport master (
        output rx_dat,
        output rx_stb,
        output rx_err,
        output busy
    );

    modport slave (
        input rx_dat,
        input rx_stb,
        input rx_err,
        input busy
    );

endinterface

// File: rtl/ps2_line_filter.sv
// 2-flop synchronizer plus run-length glitch filter for a PS/2 line.
module ps2_line_filter
    import ps2_receiver_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] RUN_MAX = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] run;

    // level flips only after FILTER_LEN consecutive samples disagree with it
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            run   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            fall <= 1'b0;
            if (sync[1] == level) begin
                run <= '0;
            end else if (run == RUN_MAX) begin
                level <= sync[1];
                run   <= '0;
                fall  <= level;
            end else begin
                run <= run + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard-to-host frame receiver: start, 8 data bits LSB first,
// odd parity, stop; with frame timeout driven by the sixus tick.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int FILTER_LEN    = FILTER_LEN_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     sixus,
    input  logic     ps2_clk_in,
    input  logic     ps2_dat_in,
    ps2_rx_if.master rx
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

    logic          clk_filt;
    logic          clk_fall;
    logic          fall;
    logic [1:0]    dat_sync;
    logic          dat;
    ps2_state_e    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2_clk_in),
        .level(clk_filt),
        .fall (clk_fall)
    );

    assign fall    = clk_fall & ~clk_filt;
    assign dat     = dat_sync[1];
    assign rx.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_sync <= 2'b11;
        end else begin
            dat_sync <= {dat_sync[0], ps2_dat_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tmo       <= '0;
            rx.rx_dat <= '0;
            rx.rx_stb <= 1'b0;
            rx.rx_err <= 1'b0;
        end else begin
            rx.rx_stb <= 1'b0;
            rx.rx_err <= 1'b0;
            if (fall) begin
                tmo <= '0;
                unique case (state)
                    IDLE: begin
                        if (!dat) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            rx.rx_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dat && ^{shreg, par_bit}) begin
                            rx.rx_dat <= shreg;
                            rx.rx_stb <= 1'b1;
                        end else begin
                            rx.rx_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tmo <= '0;
            end else if (sixus) begin
                // a stalled frame is abandoned so the next one can sync
                if (tmo == TMO_LAST) begin
                    state     <= IDLE;
                    tmo       <= '0;
                    rx.rx_err <= 1'b1;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: directed frames, glitches, timeout, reset.
module tb_ps2_receiver;
    import ps2_receiver_pkg::*;

    localparam int H = 40;

    typedef struct packed {
        logic       err;
        logic [7:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sixus = 1'b0;
    logic ps2_clk_in = 1'b1;
    logic ps2_dat_in = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];

    ps2_rx_if rx ();

    ps2_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .sixus     (sixus),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .rx        (rx.master)
    );

    always #5 clk = ~clk;

    // sixus compressed to one pulse every 4 clocks
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sixus = 1'b1;
            @(negedge clk);
            sixus = 1'b0;
        end
    end

    logic stb_d = 1'b0;
    logic err_d = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rx.rx_stb && rx.rx_err) begin
            vectors++;
            miscompares++;
            $display("FAIL both_pulses: stb=%0b err=%0b, required not both",
                     rx.rx_stb, rx.rx_err);
        end else if (rx.rx_stb || rx.rx_err) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: stb=%0b err=%0b dat=%h, none expected",
                         rx.rx_stb, rx.rx_err, rx.rx_dat);
            end else begin
                e = q.pop_front();
                if (e.err != rx.rx_err || e.dat != rx.rx_dat) begin
                    miscompares++;
                    $display("FAIL event: got err=%0b dat=%h, required err=%0b dat=%h",
                             rx.rx_err, rx.rx_dat, e.err, e.dat);
                end
            end
        end
        if ((rx.rx_stb && stb_d) || (rx.rx_err && err_d)) begin
            vectors++;
            miscompares++;
            $display("FAIL pulse_width: stb/err high 2 cycles, required 1");
        end
        stb_d = rx.rx_stb;
        err_d = rx.rx_err;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop,
                        input int glitch_idx, input int nbits);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat_in = f[i];
            wait_cyc(H / 2);
            ps2_clk_in = 1'b0;
            wait_cyc(H);
            ps2_clk_in = 1'b1;
            if (i == glitch_idx) begin
                wait_cyc(25);
                ps2_clk_in = 1'b0;
                wait_cyc(10);
                ps2_clk_in = 1'b1;
            end
            wait_cyc(H / 2);
        end
        ps2_dat_in = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dat"}, 32'(rx.rx_dat), 32'h0);
        check({tag, "_stb"}, 32'(rx.rx_stb), 32'h0);
        check({tag, "_err"}, 32'(rx.rx_err), 32'h0);
        check({tag, "_busy"}, 32'(rx.busy), 32'h0);
    endtask

    initial begin
        wait_cyc(5);
        check_zero("reset");
        rst = 1'b0;
        wait_cyc(40);

        q.push_back('{err: 1'b0, dat: 8'h1C});
        send(8'h1C, odd_parity(8'h1C), 1'b1, -1, FRAME_BITS);
        wait_cyc(100);

        q.push_back('{err: 1'b1, dat: 8'h1C});
        send(8'hF0, ~odd_parity(8'hF0), 1'b1, -1, FRAME_BITS);
        wait_cyc(100);

        q.push_back('{err: 1'b1, dat: 8'h1C});
        send(8'h1C, odd_parity(8'h1C), 1'b0, -1, FRAME_BITS);
        wait_cyc(100);

        ps2_clk_in = 1'b0;
        wait_cyc(10);
        ps2_clk_in = 1'b1;
        wait_cyc(60);
        q.push_back('{err: 1'b0, dat: 8'h5A});
        send(8'h5A, odd_parity(8'h5A), 1'b1, 4, FRAME_BITS);
        wait_cyc(100);

        q.push_back('{err: 1'b1, dat: 8'h5A});
        send(8'hA5, odd_parity(8'hA5), 1'b1, -1, 5);
        check("busy_mid_frame", 32'(rx.busy), 32'h1);
        wait_cyc(1500);
        check("busy_after_timeout", 32'(rx.busy), 32'h0);

        q.push_back('{err: 1'b0, dat: 8'h29});
        send(8'h29, odd_parity(8'h29), 1'b1, -1, FRAME_BITS);
        wait_cyc(100);

        send(8'h33, odd_parity(8'h33), 1'b1, -1, 6);
        check("busy_before_rst", 32'(rx.busy), 32'h1);
        rst = 1'b1;
        wait_cyc(3);
        check_zero("mid_rst");
        rst = 1'b0;
        wait_cyc(1);
        check_zero("post_rst");
        wait_cyc(60);

        q.push_back('{err: 1'b0, dat: 8'h1C});
        send(8'h1C, odd_parity(8'h1C), 1'b1, -1, FRAME_BITS);
        wait_cyc(200);

        check("pending_events", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
